// File: rtl/rosc_pkg.sv
// Shared definitions for the ring-oscillator bit collector: FSM state
// encoding, default geometry and a counter-width helper.
package rosc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } rosc_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SAMPLE_DIV = 16;

  // Width of a counter that must hold values 0..n-1, never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rosc_vn_debias.sv
// Von Neumann corrector: pairs consecutive samples, emits the first bit of a
// pair when the two bits differ (01 -> 0, 10 -> 1) and drops equal pairs.
// The module exists only when ROSC_VN_DEBIAS_EN is defined; without it the
// collector accepts every sample directly.
`ifdef ROSC_VN_DEBIAS_EN
module rosc_vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample_valid,
  input  logic sample_bit,
  output logic bit_valid,
  output logic bit_out
);

  logic pend_valid_q, pend_valid_d;
  logic pend_bit_q, pend_bit_d;

  // Second sample of a pair decides; the stored first bit is the output.
  assign bit_valid = sample_valid && !clear && pend_valid_q && (pend_bit_q != sample_bit);
  assign bit_out   = pend_bit_q;

  // Pair tracking: first sample is stored, second sample closes the pair.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_bit_d   = pend_bit_q;
    if (clear) begin
      pend_valid_d = 1'b0;
      pend_bit_d   = 1'b0;
    end else if (sample_valid) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_bit_d   = sample_bit;
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  // Pending-pair registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_bit_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_bit_q   <= pend_bit_d;
    end
  end

endmodule
`endif

// File: rtl/rosc_bit_collector.sv
// Samples the registered oscillator bit every SAMPLE_DIV cycles, packs the
// accepted bits MSB-first into a DATA_WIDTH word and offers it through a
// valid/ack handshake. Optional von Neumann debiasing: ROSC_VN_DEBIAS_EN.
//
// Handshake: data_valid stays high with data stable until the cycle in which
// data_ack is also high; that cycle is the transfer. Sampling is stalled
// while a word is pending. state_dbg exposes the FSM state.
module rosc_bit_collector
  import rosc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rosc_dout,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  sample_strobe,
  output rosc_state_e           state_dbg
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV);
  localparam int BIT_W = cnt_width(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_WIDTH);

  rosc_state_e           state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  acc_valid;
  logic                  acc_bit;

  // A sample is taken only while actively collecting and at the end of a
  // divider period; dropping enable suppresses the sample of that cycle.
  assign sample_strobe = (state_q == COLLECT) && enable && (div_cnt_q == DIV_LAST);

`ifdef ROSC_VN_DEBIAS_EN
  logic vn_clear;
  // Any exit from active collection discards a half-finished pair.
  assign vn_clear = !((state_q == COLLECT) && enable);

  rosc_vn_debias u_vn_debias (
    .clk          (clk),
    .reset        (reset),
    .clear        (vn_clear),
    .sample_valid (sample_strobe),
    .sample_bit   (rosc_dout),
    .bit_valid    (acc_valid),
    .bit_out      (acc_bit)
  );
`else
  assign acc_valid = sample_strobe;
  assign acc_bit   = rosc_dout;
`endif

  assign data       = data_q;
  assign data_valid = valid_q;
  assign state_dbg  = state_q;

  // Next-state, counters, packing and handshake.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
          if (acc_valid) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], acc_bit};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_d == BIT_FULL) begin
              data_d    = shift_d;
              valid_d   = 1'b1;
              div_cnt_d = '0;
              state_d   = FULL;
            end
          end
        end
      end
      FULL: begin
        div_cnt_d = '0;
        if (valid_q && data_ack) begin
          valid_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = enable ? COLLECT : IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_rosc_bit_collector.sv
// Bench for rosc_bit_collector (SAMPLE_DIV=4; DATA_WIDTH=8 plain, 4 with
// ROSC_VN_DEBIAS_EN). Words are fed bit-by-bit at observed strobes, expected
// words are queued and compared when data_valid rises.
module tb_rosc_bit_collector;
  import rosc_pkg::*;

  localparam int S = 4;
`ifdef ROSC_VN_DEBIAS_EN
  localparam int DW = 4;
`else
  localparam int DW = 8;
`endif

  typedef struct {
    logic [31:0]   samples;
    int            n;
    logic [DW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          rosc_dout = 1'b0;
  logic          data_ack = 1'b0;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          sample_strobe;
  rosc_state_e   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic prev_valid = 1'b0;

  rosc_bit_collector #(.DATA_WIDTH(DW), .SAMPLE_DIV(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .rosc_dout     (rosc_dout),
    .data_ack      (data_ack),
    .data          (data),
    .data_valid    (data_valid),
    .sample_strobe (sample_strobe),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each newly presented word against the queue head.
  always @(negedge clk) begin
    if (data_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", data);
      end else begin
        check("word", 32'(data), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = data_valid;
  end

  // Drive n samples (MSB first) at observed strobes; random noise otherwise.
  task automatic feed(input logic [31:0] samples, input int n,
                      output int first_strobe, output int cyc_cnt);
    int idx;
    int early;
    idx = 0;
    early = 0;
    cyc_cnt = 0;
    first_strobe = -1;
    while (idx < n && cyc_cnt < n * S + 50) begin
      @(negedge clk);
      cyc_cnt++;
      if (data_valid) early++;
      if (sample_strobe) begin
        if (idx == 0) first_strobe = cyc_cnt;
        rosc_dout = samples[n-1-idx];
        idx++;
      end else begin
        rosc_dout = 1'($urandom_range(0, 1));
      end
    end
    check("feed_done", 32'(idx), 32'(n));
    check("no_early_valid", 32'(early), 32'd0);
  endtask

  task automatic wait_valid(inout int cyc_cnt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cyc_cnt++;
      if (data_valid) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
  endtask

  // Ack in the current cycle; data_valid must be low one cycle later.
  task automatic ack_and_check(input string name);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check(name, 32'(data_valid), 32'd0);
  endtask

  task automatic run_word(input vec_t v);
    int fs, c;
    exp_q.push_back(v.exp);
    feed(v.samples, v.n, fs, c);
    wait_valid(c);
    ack_and_check("table_ack");
  endtask

  vec_t vecs[4];
  vec_t timed_v, fresh_v, full_v;
  logic [31:0] junk3;

  initial begin
    int fs, c, cnt, strobes, changes, bad_gap, last, valids;
    logic [DW-1:0] held;

`ifdef ROSC_VN_DEBIAS_EN
    timed_v = '{samples: 32'h2D9, n: 12, exp: 4'hA};
    vecs[0] = '{samples: 32'h5A,  n: 8,  exp: 4'h3};
    vecs[1] = '{samples: 32'h8B9, n: 12, exp: 4'hE};
    vecs[2] = '{samples: 32'h746, n: 12, exp: 4'h1};
    vecs[3] = '{samples: 32'hAA,  n: 8,  exp: 4'hF};
    fresh_v = '{samples: 32'h66,  n: 8,  exp: 4'h5};
    full_v  = '{samples: 32'h9A,  n: 8,  exp: 4'hB};
    junk3   = 32'h5;
`else
    timed_v = '{samples: 32'hB2, n: 8, exp: 8'hB2};
    vecs[0] = '{samples: 32'h5A, n: 8, exp: 8'h5A};
    vecs[1] = '{samples: 32'hFF, n: 8, exp: 8'hFF};
    vecs[2] = '{samples: 32'h00, n: 8, exp: 8'h00};
    vecs[3] = '{samples: 32'h81, n: 8, exp: 8'h81};
    fresh_v = '{samples: 32'h0F, n: 8, exp: 8'h0F};
    full_v  = '{samples: 32'hC3, n: 8, exp: 8'hC3};
    junk3   = 32'h7;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Timed first word: strobe and valid latency from entering COLLECT
    enable = 1'b1;
    exp_q.push_back(timed_v.exp);
    feed(timed_v.samples, timed_v.n, fs, c);
    wait_valid(c);
    check("first_strobe_cycle", 32'(fs), 32'(S));
    check("valid_cycle", 32'(c), 32'(timed_v.n * S + 1));

    // Hold without ack: data stable, no sampling
    held = data;
    strobes = 0;
    changes = 0;
    repeat (20) begin
      rosc_dout = ~rosc_dout;
      @(negedge clk);
      if (sample_strobe) strobes++;
      if (data !== held || data_valid !== 1'b1) changes++;
    end
    check("hold_strobes", 32'(strobes), 32'd0);
    check("hold_changes", 32'(changes), 32'd0);
    check("hold_state", 32'(state_dbg), 32'(FULL));
    ack_and_check("hold_ack");
    cnt = 1;
    while (!sample_strobe && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("restrobe_cycle", 32'(cnt), 32'(S));
    enable = 1'b0;
    @(negedge clk);
    check("drop_state", 32'(state_dbg), 32'(IDLE));

    // Table of back-to-back words
    enable = 1'b1;
    for (int i = 0; i < 4; i++) run_word(vecs[i]);

    // enable dropped mid-word: next word uses fresh samples only
    feed(junk3, 3, fs, c);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    check("abort_valid", 32'(data_valid), 32'd0);
    enable = 1'b1;
    run_word(fresh_v);

    // enable dropped in FULL: word still presented, IDLE after ack
    exp_q.push_back(full_v.exp);
    feed(full_v.samples, full_v.n, fs, c);
    wait_valid(c);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("full_hold_valid", 32'(data_valid), 32'd1);
    check("full_hold_data", 32'(data), 32'(full_v.exp));
    check("full_hold_state", 32'(state_dbg), 32'(FULL));
    ack_and_check("full_ack");
    check("full_ack_state", 32'(state_dbg), 32'(IDLE));

    // Reset mid-COLLECT after 5 samples
    enable = 1'b1;
    feed(32'h1B, 5, fs, c);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_strobe", 32'(sample_strobe), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);

`ifdef ROSC_VN_DEBIAS_EN
    // Stuck-at-1 source: strobes continue, no word ever completes
    rosc_dout = 1'b1;
    enable = 1'b1;
    strobes = 0;
    bad_gap = 0;
    last = 0;
    valids = 0;
    for (int i = 1; i <= 10000; i++) begin
      @(negedge clk);
      if (data_valid) valids++;
      if (sample_strobe) begin
        if (i - last != S) bad_gap++;
        last = i;
        strobes++;
      end
    end
    check("stuck_valids", 32'(valids), 32'd0);
    check("stuck_strobes", 32'(strobes), 32'(10000 / S));
    check("stuck_gaps", 32'(bad_gap), 32'd0);
    enable = 1'b0;
    @(negedge clk);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rosc_bit_collector.md
# rosc_bit_collector

Downstream consumer of the ring-oscillator test stage. Samples the registered single-bit oscillator output at a programmable decimation rate, optionally removes bias with a von Neumann corrector, and packs the resulting bits MSB-first into a DATA_WIDTH-bit word. Completed words are handed to the entropy mixer through a valid/ack handshake. Sampling stalls while a word is pending.

## Interface
- DATA_WIDTH, 32: bits per output word; minimum 2.
- SAMPLE_DIV, 16: clock cycles between samples; minimum 1.
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- enable  in  1  collection enable
- rosc_dout  in  1  oscillator output bit, registered upstream in clk domain
- data_ack  in  1  consumer accepts data in the cycle data_valid is high
- data  out  DATA_WIDTH  packed entropy word; reset 0
- data_valid  out  1  word available; reset 0
- sample_strobe  out  1  one-cycle pulse on every rosc_dout sample; reset 0

## Operation
- FSM states: IDLE, COLLECT, FULL; reset → IDLE.
- Reset clears all counters, the shift register, the pending-pair flag, data, data_valid and sample_strobe.
- IDLE: no sampling. enable=1 → COLLECT with div_cnt=0 and bit_cnt=0.
- COLLECT:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps. At div_cnt==SAMPLE_DIV-1, sample_strobe pulses and rosc_dout is sampled.
  - Each accepted bit is shifted in at the LSB and bit_cnt increments. The first accepted bit ends up at data[DATA_WIDTH-1].
  - When bit_cnt reaches DATA_WIDTH, the shift register is copied to data, data_valid is set, and the state moves to FULL.
  - enable=0 → IDLE. The partial word, bit_cnt and any pending pair are discarded. data and data_valid are unchanged.
- FULL: no sampling, div_cnt held at 0.
  - data_valid=1 and data_ack=1 in the same cycle: data_valid clears next cycle. The state then goes to COLLECT if enable=1, otherwise IDLE. bit_cnt is cleared.
  - enable=0 has no effect while in FULL. The word is held until acked.
- data is stable whenever data_valid=1.
- data_ack while data_valid=0 is ignored.
- Counter widths are $clog2(SAMPLE_DIV) and $clog2(DATA_WIDTH+1), each minimum 1. No counter wraps other than div_cnt.

## Timing
- enable rises at edge N → COLLECT from N+1. The first sample_strobe is in cycle N+SAMPLE_DIV.
- Without debias, data_valid rises one cycle after the DATA_WIDTH-th strobe. Latency from entering COLLECT is DATA_WIDTH×SAMPLE_DIV cycles.
- After the ack cycle, the next sample_strobe comes SAMPLE_DIV cycles after COLLECT is re-entered.
- Back-to-back words are allowed. Throughput is limited only by sampling.
- reset has priority over every other input in every state, including mid-word and in FULL.

## Configuration
- ROSC_VN_DEBIAS_EN defined: the von Neumann corrector is enabled.
  - Samples are taken in pairs. The first sample sets pend_valid and is stored in pend_bit.
  - On the second sample, if the two bits differ, pend_bit is accepted (01→0, 10→1). If they are equal, the pair is dropped.
  - pend_valid clears on every second sample.
  - Word latency is variable, with a minimum of 2×DATA_WIDTH×SAMPLE_DIV cycles.
- ROSC_VN_DEBIAS_EN not defined: every sample is accepted. No pend_* registers exist.

## Structure
- Shared package rosc_pkg: state enum (IDLE, COLLECT, FULL) and defaults for DATA_WIDTH and SAMPLE_DIV.
- One natural sub-module: rosc_vn_debias. Inputs are sample strobe and bit; outputs are bit_valid and bit; it has a sync clear. It is instantiated only under ROSC_VN_DEBIAS_EN and is otherwise a pass-through.

## Test plan
- Reset mid-COLLECT after 5 bits, DATA_WIDTH=8, SAMPLE_DIV=4 → data=0, data_valid=0, sample_strobe=0 next cycle; state IDLE.
- No debias, DATA_WIDTH=8, SAMPLE_DIV=4, rosc_dout pattern 1,0,1,1,0,0,1,0 at strobes → data=8'hB2, data_valid high exactly 1 cycle after the 8th strobe (32 cycles after entering COLLECT).
- data_ack held low 20 cycles with rosc_dout toggling → data unchanged, no sample_strobe pulses. Ack → valid low next cycle; next strobe SAMPLE_DIV cycles after COLLECT is re-entered.
- enable dropped after 3 bits, then raised → next word built from 8 fresh bits only (no stale bits). enable dropped in FULL → word still presented; after ack, state IDLE.
- ROSC_VN_DEBIAS_EN, DATA_WIDTH=4, pairs 00,10,11,01,10,01 → data=4'b1010, valid after the 12th strobe.
- rosc_dout stuck at 1 with ROSC_VN_DEBIAS_EN → data_valid never asserts over 10000 cycles; sample_strobe keeps pulsing every SAMPLE_DIV cycles.
